// File: rtl/apb_arbiter_master_pkg.sv
// Shared types and constants for the two-requester APB arbiter/master.
package apb_arbiter_master_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_TIMEOUT = 15;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned REG_W       = 3;
  localparam int unsigned SEL_BIT     = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Latched command of the granted requester
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  // 0 selects slave1, 1 selects slave2
  function automatic logic slave_of(input logic [ADDR_W-1:0] addr);
    return addr[SEL_BIT];
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter: last-grant pointer plus combinational grant.
module apb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic [1:0] gnt_c
);

  // 1 = requester 1 served last, so requester 0 wins a tie after reset
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= upd_idx;
    end
  end

  always_comb begin
    gnt_c = 2'b00;
    if (req == 2'b11) begin
      gnt_c = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt_c = req;
    end
  end

endmodule

// File: rtl/apb_arbiter_master.sv
// APB master shared by two requesters; round-robin arbitration, wait-state
// timeout with error reporting, registered completion pulses.
module apb_arbiter_master
  import apb_arbiter_master_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [REG_W-1:0]  Paddr,
  output logic              Pwrite,
  output logic              Penable,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Psel1,
  output logic              Psel2,
  input  logic [DATA_W-1:0] Prdata1,
  input  logic [DATA_W-1:0] Prdata2,
  input  logic              Pready1,
  input  logic              Pready2
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  cmd_t              cmd_q;
  logic              owner_q;
  logic [CNT_W-1:0]  wcnt_q;
  logic [1:0]        req_vec;
  logic [1:0]        gnt;
  logic              sel_ready_c;
  logic [DATA_W-1:0] sel_rdata_c;
  logic              timeout_c;
  logic              finish_c;

  // A requester still sees its own done pulse this cycle, so its held request is ignored
  assign req_vec = {req1 & ~done1, req0 & ~done0};

  apb_rr_arb2 u_arb (
    .clk    (Pclk),
    .rst_n  (Prst),
    .req    (req_vec),
    .upd    (finish_c),
    .upd_idx(owner_q),
    .gnt_c  (gnt)
  );

  assign sel_ready_c = slave_of(cmd_q.addr) ? Pready2 : Pready1;
  assign sel_rdata_c = slave_of(cmd_q.addr) ? Prdata2 : Prdata1;
  assign timeout_c   = (state_q == ST_ACCESS) && !sel_ready_c
                       && (wcnt_q == CNT_W'(TIMEOUT - 1));
  assign finish_c    = (state_q == ST_ACCESS) && (sel_ready_c || timeout_c);

  assign Paddr  = cmd_q.addr[REG_W-1:0];
  assign Pwrite = cmd_q.wr;

  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|gnt) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (finish_c) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Bus, command and response registers
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      cmd_q   <= '0;
      owner_q <= 1'b0;
      wcnt_q  <= '0;
      Pwdata  <= '0;
      Psel1   <= 1'b0;
      Psel2   <= 1'b0;
      Penable <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            owner_q    <= gnt[1];
            cmd_q.wr   <= gnt[1] ? wr1 : wr0;
            cmd_q.addr <= gnt[1] ? addr1 : addr0;
            Pwdata     <= gnt[1] ? wdata1 : wdata0;
            Psel1      <= ~slave_of(gnt[1] ? addr1 : addr0);
            Psel2      <= slave_of(gnt[1] ? addr1 : addr0);
            wcnt_q     <= '0;
          end
        end
        ST_SETUP: begin
          Penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (finish_c) begin
            Psel1   <= 1'b0;
            Psel2   <= 1'b0;
            Penable <= 1'b0;
            err     <= timeout_c;
            if (owner_q) done1 <= 1'b1;
            else         done0 <= 1'b1;
            if (sel_ready_c && !cmd_q.wr) rdata <= sel_rdata_c;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Randomized scoreboard bench for apb_arbiter_master with two APB slave models.
module tb_apb_arbiter_master;

  localparam int unsigned DW = 16;
  localparam int TO = 15;

  logic          Pclk = 1'b0;
  logic          Prst;
  logic          req0, req1, wr0, wr1;
  logic [3:0]    addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, done1, err;
  logic [DW-1:0] rdata;
  logic [2:0]    Paddr;
  logic          Pwrite, Penable, Psel1, Psel2;
  logic [DW-1:0] Pwdata;
  logic [DW-1:0] Prdata1, Prdata2;
  logic          Pready1, Pready2;

  always #5 Pclk = ~Pclk;

  apb_arbiter_master #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .Pclk(Pclk), .Prst(Prst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .Paddr(Paddr), .Pwrite(Pwrite), .Penable(Penable), .Pwdata(Pwdata),
    .Psel1(Psel1), .Psel2(Psel2),
    .Prdata1(Prdata1), .Prdata2(Prdata2), .Pready1(Pready1), .Pready2(Pready2)
  );

  typedef struct {
    int            who;
    bit            err;
    logic [DW-1:0] rdata;
    int            lat;
  } exp_t;

  typedef struct {
    bit            slave;
    logic [2:0]    idx;
    bit            wr;
    logic [DW-1:0] wdata;
  } bus_t;

  exp_t          sb[$];
  bus_t          bq[$];
  logic [DW-1:0] ref_mem[2][8];
  logic [DW-1:0] mem1[8];
  logic [DW-1:0] mem2[8];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            start_cyc[2];
  bit            tog = 1'b0;
  int            tgt1 = 0, tgt2 = 0;
  int            cnt1 = 0, cnt2 = 0;
  int            m_last = 1;
  logic [DW-1:0] m_rdata = '0;

  always @(posedge Pclk) cyc++;

  // Slave models: Pready after tgtN wait cycles; idle slaves optionally toggle Pready
  always @(negedge Pclk) begin
    if (Psel1 && Penable) begin
      if (cnt1 == tgt1) begin
        Pready1 = 1'b1;
        Prdata1 = mem1[Paddr];
        if (Pwrite) mem1[Paddr] = Pwdata;
      end else begin
        Pready1 = 1'b0;
        Prdata1 = 16'($urandom);
      end
      cnt1++;
    end else begin
      cnt1 = 0;
      Pready1 = tog ? 1'($urandom) : 1'b0;
      Prdata1 = 16'($urandom);
    end
    if (Psel2 && Penable) begin
      if (cnt2 == tgt2) begin
        Pready2 = 1'b1;
        Prdata2 = mem2[Paddr];
        if (Pwrite) mem2[Paddr] = Pwdata;
      end else begin
        Pready2 = 1'b0;
        Prdata2 = 16'($urandom);
      end
      cnt2++;
    end else begin
      cnt2 = 0;
      Pready2 = tog ? 1'($urandom) : 1'b0;
      Prdata2 = 16'($urandom);
    end
  end

  function automatic bit bus_ok(input bus_t b);
    return (Psel2 == b.slave) && (Psel1 == !b.slave) && (Paddr == b.idx)
           && (Pwrite == b.wr) && (!b.wr || Pwdata == b.wdata);
  endfunction

  // Monitor: bus protocol, SETUP/ACCESS contents, and done responses vs scoreboard
  bus_t cur;
  bit   have_cur = 1'b0;
  always @(negedge Pclk) begin
    if (!Prst) begin
      have_cur = 1'b0;
    end else begin
      checks++;
      if ((Psel1 && Psel2) || (Penable && !Psel1 && !Psel2)) begin
        errors++;
        $display("FAIL psel_excl: Psel1=%b Psel2=%b Penable=%b, required one select at most and Penable only with a select",
                 Psel1, Psel2, Penable);
      end
      if ((Psel1 || Psel2) && !Penable) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL bus_setup: unexpected SETUP Paddr=%0d, required no transfer", Paddr);
        end else begin
          cur = bq.pop_front();
          have_cur = 1'b1;
          if (!bus_ok(cur)) begin
            errors++;
            $display("FAIL bus_setup: sel=%b%b addr=%0d wr=%b wdata=%h, required slave=%0d addr=%0d wr=%b wdata=%h",
                     Psel2, Psel1, Paddr, Pwrite, Pwdata, cur.slave + 1, cur.idx, cur.wr, cur.wdata);
          end
        end
      end else if (Penable && have_cur) begin
        checks++;
        if (!bus_ok(cur)) begin
          errors++;
          $display("FAIL bus_hold: sel=%b%b addr=%0d wr=%b wdata=%h, required slave=%0d addr=%0d wr=%b wdata=%h",
                   Psel2, Psel1, Paddr, Pwrite, Pwdata, cur.slave + 1, cur.idx, cur.wr, cur.wdata);
        end
      end
      if (done0 || done1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done0=%b done1=%b, required none", done0, done1);
        end else begin
          exp_t e;
          int   lat;
          e = sb.pop_front();
          lat = cyc - start_cyc[e.who];
          if (done0 != (e.who == 0) || done1 != (e.who == 1) || err != e.err
              || rdata != e.rdata || (e.lat >= 0 && lat != e.lat)) begin
            errors++;
            $display("FAIL done_resp: done0=%b done1=%b err=%b rdata=%h lat=%0d, required requester%0d err=%b rdata=%h lat=%0d",
                     done0, done1, err, rdata, lat, e.who, e.err, e.rdata, e.lat);
          end
        end
      end
    end
  end

  // Reference model: slave register file, last-read value and fairness pointer
  function automatic void predict(input int idx, input bit wr, input logic [3:0] a,
                                  input logic [DW-1:0] d, input bit single);
    int   waits;
    bit   to;
    exp_t e;
    bus_t b;
    waits = a[3] ? tgt2 : tgt1;
    to = waits >= TO;
    b.slave = a[3]; b.idx = a[2:0]; b.wr = wr; b.wdata = d;
    bq.push_back(b);
    if (!to) begin
      if (wr) ref_mem[a[3]][a[2:0]] = d;
      else    m_rdata = ref_mem[a[3]][a[2:0]];
    end
    e.who = idx; e.err = to; e.rdata = m_rdata;
    e.lat = single ? (to ? 2 + TO : 3 + waits) : -1;
    sb.push_back(e);
    m_last = idx;
  endfunction

  task automatic requester(input int idx, input bit wr, input logic [3:0] a, input logic [DW-1:0] d);
    int n = 0;
    if (idx == 0) begin wr0 = wr; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else          begin wr1 = wr; addr1 = a; wdata1 = d; req1 = 1'b1; end
    start_cyc[idx] = cyc;
    do begin
      @(negedge Pclk);
      n++;
    end while (!(idx == 0 ? done0 : done1) && n < 200);
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL req%0d_wait: no done after %0d cycles, required a done pulse", idx, n);
    end
    if (idx == 0) req0 = 1'b0;
    else          req1 = 1'b0;
  endtask

  task automatic round(input bit u0, input bit u1,
                       input bit w0, input logic [3:0] a0, input logic [DW-1:0] d0,
                       input bit w1, input logic [3:0] a1, input logic [DW-1:0] d1,
                       input int t1, input int t2);
    bit single;
    tgt1 = t1; tgt2 = t2;
    @(negedge Pclk);
    single = !(u0 && u1);
    if (u0 && u1) begin
      if (m_last == 0) begin predict(1, w1, a1, d1, 0); predict(0, w0, a0, d0, 0); end
      else             begin predict(0, w0, a0, d0, 0); predict(1, w1, a1, d1, 0); end
    end else if (u0) predict(0, w0, a0, d0, 1);
    else             predict(1, w1, a1, d1, 1);
    fork
      if (u0) requester(0, w0, a0, d0);
      if (u1) requester(1, w1, a1, d1);
    join
  endtask

  task automatic rand_round();
    bit u0, u1;
    u0 = 1'($urandom); u1 = 1'($urandom);
    if (!u0 && !u1) u0 = 1'b1;
    round(u0, u1, 1'($urandom), 4'($urandom), 16'($urandom),
          1'($urandom), 4'($urandom), 16'($urandom),
          ($urandom_range(0, 7) == 0) ? 16 : int'($urandom_range(0, 4)),
          ($urandom_range(0, 7) == 0) ? 16 : int'($urandom_range(0, 4)));
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({rdata, err, done0, done1, Psel1, Psel2, Penable, Pwrite, Paddr, Pwdata} != '0) begin
      errors++;
      $display("FAIL %s: rdata=%h err=%b done=%b%b psel=%b%b Penable=%b Pwrite=%b Paddr=%0d Pwdata=%h, required all zero",
               name, rdata, err, done1, done0, Psel2, Psel1, Penable, Pwrite, Paddr, Pwdata);
    end
  endtask

  initial begin
    int n;
    Prst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 8; i++) begin
      mem1[i] = 16'($urandom); mem2[i] = 16'($urandom);
      ref_mem[0][i] = mem1[i]; ref_mem[1][i] = mem2[i];
    end
    mem2[3] = 16'hFFF0; ref_mem[1][3] = 16'hFFF0;
    repeat (3) @(negedge Pclk);
    check_reset_outputs("reset_state");
    #2 Prst = 1'b1;

    // Single write, zero waits; then a read from slave2 with four waits
    round(1, 0, 1, 4'h2, 16'h00A5, 0, 4'h0, 16'h0, 0, 0);
    round(0, 1, 0, 4'h0, 16'h0, 0, 4'hB, 16'h0, 0, 4);

    // Simultaneous requests must alternate
    for (int i = 0; i < 4; i++)
      round(1, 1, 1'($urandom), 4'($urandom), 16'($urandom),
            1'($urandom), 4'($urandom), 16'($urandom), i % 3, (i + 1) % 3);

    // Slave never ready: timeout with err and unchanged rdata
    round(1, 0, 0, 4'h5, 16'h0, 0, 4'h0, 16'h0, 99, 0);
    round(0, 1, 1, 4'h0, 16'h0, 1, 4'hC, 16'h1234, 0, 99);

    // Reset in the middle of ACCESS
    tgt1 = 8;
    @(negedge Pclk);
    begin
      bus_t b;
      b.slave = 1'b0; b.idx = 3'd5; b.wr = 1'b1; b.wdata = 16'hBEEF;
      bq.push_back(b);
    end
    wr0 = 1'b1; addr0 = 4'h5; wdata0 = 16'hBEEF; req0 = 1'b1;
    n = 0;
    while (!Penable && n < 20) begin @(negedge Pclk); n++; end
    checks++;
    if (!Penable) begin
      errors++;
      $display("FAIL reset_setup: Penable=%b, required ACCESS before reset", Penable);
    end
    @(negedge Pclk);
    #2 Prst = 1'b0;
    #1 check_reset_outputs("reset_mid_access");
    req0 = 1'b0;
    m_last = 1; m_rdata = '0;
    repeat (2) @(negedge Pclk);
    #2 Prst = 1'b1;
    repeat (3) @(negedge Pclk);
    round(1, 0, 0, 4'h5, 16'h0, 0, 4'h0, 16'h0, 1, 0);
    round(1, 1, 0, 4'h2, 16'h0, 0, 4'hB, 16'h0, 2, 1);

    // Unselected slave toggles Pready throughout
    tog = 1'b1;
    round(1, 0, 0, 4'h2, 16'h0, 0, 4'h0, 16'h0, 3, 0);
    round(0, 1, 0, 4'h0, 16'h0, 0, 4'hB, 16'h0, 0, 2);
    for (int i = 0; i < 40; i++) begin
      tog = (i % 2) == 0;
      rand_round();
    end
    tog = 1'b0;
    repeat (5) @(negedge Pclk);

    checks++;
    if (sb.size() != 0 || bq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses and %0d bus phases outstanding, required 0 and 0", sb.size(), bq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
